// File: rtl/demux_12_4_cond_pkg.sv
// Shared selector encoding, default width and reset values
// for the 1:2 word demultiplexer.
package demux_12_4_cond_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;

  localparam logic RST_DATA_BIT = 1'b0;
  localparam logic RST_STROBE   = 1'b0;
  localparam logic RST_HAVE_A   = 1'b0;

endpackage

// File: rtl/demux_sel_fsm.sv
// Alternating A/B selector with pair tracking.
// Ports: clk, Reset, Q_valid in; S, cap_a, cap_b, pair_valid out.
module demux_sel_fsm
  import demux_12_4_cond_pkg::*;
#(
  parameter bit FIRST_SEL = 1'b0
) (
  input  logic clk,
  input  logic Reset,
  input  logic Q_valid,
  output logic S,
  output logic cap_a,
  output logic cap_b,
  output logic pair_valid
);

  localparam sel_e RST_SEL = sel_e'(FIRST_SEL);

  sel_e state;
  sel_e state_nxt;
  logic have_a;
  logic have_a_nxt;
  logic pair_nxt;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state      <= RST_SEL;
      have_a     <= RST_HAVE_A;
      pair_valid <= RST_STROBE;
    end else begin
      state      <= state_nxt;
      have_a     <= have_a_nxt;
      pair_valid <= pair_nxt;
    end
  end

  // cap_a/cap_b are same-cycle load enables for
  // the data registers in the parent.
  always_comb begin
    state_nxt  = state;
    have_a_nxt = have_a;
    pair_nxt   = 1'b0;
    cap_a      = 1'b0;
    cap_b      = 1'b0;
    if (Q_valid) begin
      unique case (state)
        SEL_A: begin
          cap_a      = 1'b1;
          have_a_nxt = 1'b1;
          state_nxt  = SEL_B;
        end
        SEL_B: begin
          cap_b      = 1'b1;
          have_a_nxt = 1'b0;
          pair_nxt   = have_a;
          state_nxt  = SEL_A;
        end
      endcase
    end
  end

  assign S = state;

endmodule

// File: rtl/demux_12_4_cond.sv
// 1:2 demux: valid words alternate to registered A and B.
// Ports: clk, Reset, Q, Q_valid in; A, B, A_valid, B_valid,
// pair_valid, S out. DEMUX_PARITY_EN adds Q_par in, par_err out.
module demux_12_4_cond
  import demux_12_4_cond_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit FIRST_SEL = 1'b0
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Q,
  input  logic             Q_valid,
`ifdef DEMUX_PARITY_EN
  input  logic             Q_par,
  output logic             par_err,
`endif
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             A_valid,
  output logic             B_valid,
  output logic             pair_valid,
  output logic             S
);

  logic cap_a;
  logic cap_b;

  demux_sel_fsm #(
    .FIRST_SEL (FIRST_SEL)
  ) u_fsm (
    .clk        (clk),
    .Reset      (Reset),
    .Q_valid    (Q_valid),
    .S          (S),
    .cap_a      (cap_a),
    .cap_b      (cap_b),
    .pair_valid (pair_valid)
  );

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      A       <= {WIDTH{RST_DATA_BIT}};
      B       <= {WIDTH{RST_DATA_BIT}};
      A_valid <= RST_STROBE;
      B_valid <= RST_STROBE;
    end else begin
      A_valid <= cap_a;
      B_valid <= cap_b;
      if (cap_a) A <= Q;
      if (cap_b) B <= Q;
    end
  end

`ifdef DEMUX_PARITY_EN
  // Bad words are still routed; the flag only reports them.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)
      par_err <= RST_STROBE;
    else if (Q_valid)
      par_err <= ^{Q, Q_par};
  end
`endif

endmodule

// File: tb/tb_demux_12_4_cond.sv
// Directed scoreboard bench for demux_12_4_cond:
// one instance per FIRST_SEL value, shared clock and reset.
module tb_demux_12_4_cond;

  logic       clk = 1'b0;
  logic       Reset;
  logic [3:0] q0, q1;
  logic       v0, v1, p0, p1;
  logic [3:0] a0, b0, a1, b1;
  logic       av0, bv0, pv0, s0, pe0;
  logic       av1, bv1, pv1, s1, pe1;

  always #5 clk = ~clk;

  demux_12_4_cond #(.WIDTH(4), .FIRST_SEL(1'b0)) dut0 (
    .clk        (clk),
    .Reset      (Reset),
    .Q          (q0),
    .Q_valid    (v0),
`ifdef DEMUX_PARITY_EN
    .Q_par      (p0),
    .par_err    (pe0),
`endif
    .A          (a0),
    .B          (b0),
    .A_valid    (av0),
    .B_valid    (bv0),
    .pair_valid (pv0),
    .S          (s0)
  );

  demux_12_4_cond #(.WIDTH(4), .FIRST_SEL(1'b1)) dut1 (
    .clk        (clk),
    .Reset      (Reset),
    .Q          (q1),
    .Q_valid    (v1),
`ifdef DEMUX_PARITY_EN
    .Q_par      (p1),
    .par_err    (pe1),
`endif
    .A          (a1),
    .B          (b1),
    .A_valid    (av1),
    .B_valid    (bv1),
    .pair_valid (pv1),
    .S          (s1)
  );

`ifndef DEMUX_PARITY_EN
  assign pe0 = 1'b0;
  assign pe1 = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       av;
    logic       bv;
    logic       pv;
    logic       s;
    logic       pe;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       s;
    logic       have;
    logic       pe;
  } mst_t;

  mst_t m0, m1;
  exp_t sb0[$];
  exp_t sb1[$];
  int n_assert = 0;
  int n_fail   = 0;

  function automatic mst_t mreset(input logic fs);
    mst_t r;
    r.a = 4'h0; r.b = 4'h0; r.s = fs;
    r.have = 1'b0; r.pe = 1'b0;
    return r;
  endfunction

  task automatic model(inout mst_t st, input logic fs,
                       input logic rst, input logic [3:0] q,
                       input logic v, input logic p,
                       output exp_t e);
    e.av = 1'b0; e.bv = 1'b0; e.pv = 1'b0;
    if (rst) st = mreset(fs);
    else if (v) begin
      if (!st.s) begin
        st.a = q; e.av = 1'b1; st.have = 1'b1;
      end else begin
        st.b = q; e.bv = 1'b1; e.pv = st.have;
        st.have = 1'b0;
      end
      st.s = ~st.s;
`ifdef DEMUX_PARITY_EN
      st.pe = ^{q, p};
`endif
    end
    e.a = st.a; e.b = st.b; e.s = st.s; e.pe = st.pe;
  endtask

  task automatic check(input string tag, input exp_t obs,
                       input exp_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag,
                      input logic [3:0] nq0, input logic nv0,
                      input logic np0,
                      input logic [3:0] nq1, input logic nv1,
                      input logic np1);
    exp_t e0, e1, x0, x1;
    q0 = nq0; v0 = nv0; p0 = np0;
    q1 = nq1; v1 = nv1; p1 = np1;
    model(m0, 1'b0, Reset, nq0, nv0, np0, e0);
    model(m1, 1'b1, Reset, nq1, nv1, np1, e1);
    sb0.push_back(e0);
    sb1.push_back(e1);
    @(posedge clk);
    #1;
    x0 = sb0.pop_front();
    x1 = sb1.pop_front();
    check({tag, "/d0"}, {a0, b0, av0, bv0, pv0, s0, pe0}, x0);
    check({tag, "/d1"}, {a1, b1, av1, bv1, pv1, s1, pe1}, x1);
  endtask

  initial begin
    Reset = 1'b1;
    q0 = 4'h0; v0 = 1'b0; p0 = 1'b0;
    q1 = 4'h0; v1 = 1'b0; p1 = 1'b0;
    m0 = mreset(1'b0);
    m1 = mreset(1'b1);

    // word offered during reset is discarded
    step("rst_hold", 4'hF, 1'b1, 1'b0, 4'hE, 1'b1, 1'b1);
    Reset = 1'b0;

    step("w3", 4'h3, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    step("w5", 4'h5, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    step("w9", 4'h9, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    step("wC", 4'hC, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);

    step("w1", 4'h1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("idle", 4'hx, 1'b0, 1'bx, 4'hx, 1'b0, 1'bx);
    step("w2", 4'h2, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);

    step("w7", 4'h7, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    m0 = mreset(1'b0);
    m1 = mreset(1'b1);
    check("async_rst/d0", {a0, b0, av0, bv0, pv0, s0, pe0},
          {4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    check("async_rst/d1", {a1, b1, av1, bv1, pv1, s1, pe1},
          {4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    step("rst_w8", 4'h8, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    Reset = 1'b0;
    step("w8", 4'h8, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);

    step("fs1_wA", 4'h0, 1'b0, 1'b0, 4'hA, 1'b1, 1'b0);
    step("fs1_wB", 4'h0, 1'b0, 1'b0, 4'hB, 1'b1, 1'b1);
    step("fs1_x", 4'hx, 1'b0, 1'bx, 4'hx, 1'b0, 1'bx);

    step("w1b", 4'h1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    step("par_bad", 4'h6, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    step("par_good", 4'h3, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    step("tail", 4'hx, 1'b0, 1'bx, 4'hx, 1'b0, 1'bx);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
